// File: rtl/pong_pkg.sv
// Shared types and defaults for the Pong game controller: state encoding,
// coordinate/score widths, default grid geometry and a counter-width helper.
package pong_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SERVE     = 3'd1,
    ST_RUNNING   = 3'd2,
    ST_POINT     = 3'd3,
    ST_GAME_OVER = 3'd4
  } state_t;

  localparam int X_W     = 6;
  localparam int Y_W     = 5;
  localparam int SCORE_W = 4;

  localparam int DEF_GAME_WIDTH    = 40;
  localparam int DEF_GAME_HEIGHT   = 30;
  localparam int DEF_PADDLE_HEIGHT = 6;
  localparam int DEF_PADDLE_COL_P1 = 0;
  localparam int DEF_PADDLE_COL_P2 = 39;

  // Width of a counter that must hold 0..n-1 (at least one bit).
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pong_paddle_ctrl.sv
// One paddle: frame-tick divider plus up/down/hold stepping with saturation
// at the top (row 0) and bottom (GAME_HEIGHT-PADDLE_HEIGHT) of the field.
// The divider is held at zero while the paddle is disabled so every
// activation starts a fresh step period.
module pong_paddle_ctrl
  import pong_pkg::*;
#(
  parameter int GAME_HEIGHT   = DEF_GAME_HEIGHT,
  parameter int PADDLE_HEIGHT = DEF_PADDLE_HEIGHT,
  parameter int PADDLE_SPEED  = 4
) (
  input  logic           clk,
  input  logic           srst,
  input  logic           enable,
  input  logic           tick,
  input  logic           up,
  input  logic           dn,
  output logic [Y_W-1:0] paddle_y
);

  localparam int CNT_W = cnt_width(PADDLE_SPEED);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PADDLE_SPEED - 1);
  localparam logic [Y_W-1:0]   Y_INIT   = Y_W'((GAME_HEIGHT - PADDLE_HEIGHT) / 2);
  localparam logic [Y_W-1:0]   Y_MAX    = Y_W'(GAME_HEIGHT - PADDLE_HEIGHT);

  logic [CNT_W-1:0] cnt_reg;
  logic [Y_W-1:0]   y_reg;

  // Divide frame ticks and move the paddle one row per step period.
  always_ff @(posedge clk) begin
    if (srst) begin
      cnt_reg <= '0;
      y_reg   <= Y_INIT;
    end else if (!enable) begin
      cnt_reg <= '0;
    end else if (tick) begin
      if (cnt_reg == CNT_LAST) begin
        cnt_reg <= '0;
        if (up && !dn && (y_reg != '0)) begin
          y_reg <= y_reg - Y_W'(1);
        end else if (dn && !up && (y_reg < Y_MAX)) begin
          y_reg <= y_reg + Y_W'(1);
        end
      end else begin
        cnt_reg <= cnt_reg + CNT_W'(1);
      end
    end
  end

  assign paddle_y = y_reg;

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong game sequencer: state machine, ball motion, paddles and scores on a
// tile grid, paced by frame ticks from the falling edge of VSync.
// Optional build macro PONG_AI_EN: when defined, the P2 paddle tracks the
// ball internally and the P2 switches are ignored.
module pong_game_ctrl
  import pong_pkg::*;
#(
  parameter int GAME_WIDTH    = DEF_GAME_WIDTH,
  parameter int GAME_HEIGHT   = DEF_GAME_HEIGHT,
  parameter int PADDLE_HEIGHT = DEF_PADDLE_HEIGHT,
  parameter int PADDLE_COL_P1 = DEF_PADDLE_COL_P1,
  parameter int PADDLE_COL_P2 = DEF_PADDLE_COL_P2,
  parameter int BALL_SPEED    = 8,
  parameter int PADDLE_SPEED  = 4,
  parameter int SERVE_FRAMES  = 60,
  parameter int SCORE_LIMIT   = 9
) (
  input  logic               i_Clk,
  input  logic               i_Rst,
  input  logic               i_VSync,
  input  logic               i_Start,
  input  logic               i_P1_Up,
  input  logic               i_P1_Dn,
  input  logic               i_P2_Up,
  input  logic               i_P2_Dn,
  output logic [X_W-1:0]     o_Ball_X,
  output logic [Y_W-1:0]     o_Ball_Y,
  output logic [Y_W-1:0]     o_P1_Paddle_Y,
  output logic [Y_W-1:0]     o_P2_Paddle_Y,
  output logic [SCORE_W-1:0] o_P1_Score,
  output logic [SCORE_W-1:0] o_P2_Score,
  output logic               o_Game_Active,
  output logic [2:0]         o_State
);

  localparam int SERVE_W = cnt_width(SERVE_FRAMES);
  localparam int BALL_W  = cnt_width(BALL_SPEED);

  localparam logic [SERVE_W-1:0] SERVE_LAST  = SERVE_W'(SERVE_FRAMES - 1);
  localparam logic [BALL_W-1:0]  BALL_LAST   = BALL_W'(BALL_SPEED - 1);
  localparam logic [X_W-1:0]     X_CENTRE    = X_W'(GAME_WIDTH / 2);
  localparam logic [Y_W-1:0]     Y_CENTRE    = Y_W'(GAME_HEIGHT / 2);
  localparam logic [Y_W-1:0]     Y_LAST      = Y_W'(GAME_HEIGHT - 1);
  localparam logic [Y_W-1:0]     PH_M1       = Y_W'(PADDLE_HEIGHT - 1);
  localparam logic [X_W-1:0]     X_P1_EDGE   = X_W'(PADDLE_COL_P1 + 1);
  localparam logic [X_W-1:0]     X_P1_BOUNCE = X_W'(PADDLE_COL_P1 + 2);
  localparam logic [X_W-1:0]     X_P2_EDGE   = X_W'(PADDLE_COL_P2 - 1);
  localparam logic [X_W-1:0]     X_P2_BOUNCE = X_W'(PADDLE_COL_P2 - 2);
  localparam logic [SCORE_W-1:0] SCORE_MAX   = SCORE_W'(SCORE_LIMIT);

  // Direction flags: 1 means +X (rightwards) / +Y (downwards).
  state_t               state_reg;
  logic                 vsync_reg, vsync_prev_reg;
  logic [X_W-1:0]       ball_x_reg;
  logic [Y_W-1:0]       ball_y_reg;
  logic                 dir_x_reg, dir_y_reg;
  logic [SCORE_W-1:0]   p1_score_reg, p2_score_reg;
  logic                 scorer_p1_reg;
  logic                 game_active_reg;
  logic [SERVE_W-1:0]   serve_cnt_reg;
  logic [BALL_W-1:0]    ball_cnt_reg;

  logic                 tick;
  logic [Y_W-1:0]       p1_y, p2_y;
  logic                 p2_up, p2_dn;

  // Ball step computed from the pre-step position and pre-step paddle rows.
  logic [X_W-1:0]       step_x_next;
  logic [Y_W-1:0]       step_y_next;
  logic                 step_dir_x_next, step_dir_y_next;
  logic                 step_miss_next, step_scorer_p1_next;
  logic                 p1_hit, p2_hit;
  logic [SCORE_W-1:0]   p1_score_inc, p2_score_inc;

  // Frame tick is the registered VSync falling edge.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      vsync_reg      <= 1'b0;
      vsync_prev_reg <= 1'b0;
    end else begin
      vsync_reg      <= i_VSync;
      vsync_prev_reg <= vsync_reg;
    end
  end

  assign tick = vsync_prev_reg & ~vsync_reg;

  assign p1_hit = (ball_y_reg >= p1_y) && (ball_y_reg <= p1_y + PH_M1);
  assign p2_hit = (ball_y_reg >= p2_y) && (ball_y_reg <= p2_y + PH_M1);

  assign p1_score_inc = (p1_score_reg >= SCORE_MAX) ? SCORE_MAX : p1_score_reg + SCORE_W'(1);
  assign p2_score_inc = (p2_score_reg >= SCORE_MAX) ? SCORE_MAX : p2_score_reg + SCORE_W'(1);

  // Next ball position/direction for one step, including wall and paddle bounces.
  always_comb begin
    step_x_next         = ball_x_reg;
    step_y_next         = ball_y_reg;
    step_dir_x_next     = dir_x_reg;
    step_dir_y_next     = dir_y_reg;
    step_miss_next      = 1'b0;
    step_scorer_p1_next = 1'b0;

    if (dir_y_reg) begin
      if (ball_y_reg == Y_LAST) begin
        step_dir_y_next = 1'b0;
        step_y_next     = ball_y_reg - Y_W'(1);
      end else begin
        step_y_next = ball_y_reg + Y_W'(1);
      end
    end else begin
      if (ball_y_reg == '0) begin
        step_dir_y_next = 1'b1;
        step_y_next     = Y_W'(1);
      end else begin
        step_y_next = ball_y_reg - Y_W'(1);
      end
    end

    if (!dir_x_reg && (ball_x_reg == X_P1_EDGE)) begin
      if (p1_hit) begin
        step_dir_x_next = 1'b1;
        step_x_next     = X_P1_BOUNCE;
      end else begin
        step_miss_next      = 1'b1;
        step_scorer_p1_next = 1'b0;
      end
    end else if (dir_x_reg && (ball_x_reg == X_P2_EDGE)) begin
      if (p2_hit) begin
        step_dir_x_next = 1'b0;
        step_x_next     = X_P2_BOUNCE;
      end else begin
        step_miss_next      = 1'b1;
        step_scorer_p1_next = 1'b1;
      end
    end else if (dir_x_reg) begin
      step_x_next = ball_x_reg + X_W'(1);
    end else begin
      step_x_next = ball_x_reg - X_W'(1);
    end
  end

  // Game state machine with ball, scores and activity flag as registered outputs.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_reg       <= ST_IDLE;
      ball_x_reg      <= X_CENTRE;
      ball_y_reg      <= Y_CENTRE;
      dir_x_reg       <= 1'b1;
      dir_y_reg       <= 1'b1;
      p1_score_reg    <= '0;
      p2_score_reg    <= '0;
      scorer_p1_reg   <= 1'b0;
      game_active_reg <= 1'b0;
      serve_cnt_reg   <= '0;
      ball_cnt_reg    <= '0;
    end else begin
      case (state_reg)
        ST_IDLE, ST_GAME_OVER: begin
          // A tick arriving with the start pulse is swallowed by the transition.
          if (i_Start) begin
            state_reg       <= ST_SERVE;
            game_active_reg <= 1'b1;
            p1_score_reg    <= '0;
            p2_score_reg    <= '0;
            ball_x_reg      <= X_CENTRE;
            ball_y_reg      <= Y_CENTRE;
            dir_x_reg       <= 1'b1;
            serve_cnt_reg   <= '0;
            ball_cnt_reg    <= '0;
          end
        end
        ST_SERVE: begin
          if (tick) begin
            if (serve_cnt_reg == SERVE_LAST) begin
              state_reg     <= ST_RUNNING;
              serve_cnt_reg <= '0;
              ball_cnt_reg  <= '0;
            end else begin
              serve_cnt_reg <= serve_cnt_reg + SERVE_W'(1);
            end
          end
        end
        ST_RUNNING: begin
          if (tick) begin
            if (ball_cnt_reg == BALL_LAST) begin
              ball_cnt_reg <= '0;
              ball_y_reg   <= step_y_next;
              dir_y_reg    <= step_dir_y_next;
              if (step_miss_next) begin
                state_reg       <= ST_POINT;
                game_active_reg <= 1'b0;
                scorer_p1_reg   <= step_scorer_p1_next;
              end else begin
                ball_x_reg <= step_x_next;
                dir_x_reg  <= step_dir_x_next;
              end
            end else begin
              ball_cnt_reg <= ball_cnt_reg + BALL_W'(1);
            end
          end
        end
        ST_POINT: begin
          if (scorer_p1_reg) begin
            p1_score_reg <= p1_score_inc;
          end else begin
            p2_score_reg <= p2_score_inc;
          end
          if ((scorer_p1_reg ? p1_score_inc : p2_score_inc) == SCORE_MAX) begin
            state_reg       <= ST_GAME_OVER;
            game_active_reg <= 1'b0;
          end else begin
            state_reg       <= ST_SERVE;
            game_active_reg <= 1'b1;
            ball_x_reg      <= X_CENTRE;
            ball_y_reg      <= Y_CENTRE;
            dir_x_reg       <= scorer_p1_reg;  // serve toward the player who lost
            dir_y_reg       <= 1'b1;
            serve_cnt_reg   <= '0;
          end
        end
        default: begin
          state_reg       <= ST_IDLE;
          game_active_reg <= 1'b0;
        end
      endcase
    end
  end

`ifdef PONG_AI_EN
  logic [Y_W-1:0] p2_centre;
  logic           unused_p2_buttons;
  assign unused_p2_buttons = i_P2_Up ^ i_P2_Dn;
  assign p2_centre = p2_y + Y_W'(PADDLE_HEIGHT / 2);
  assign p2_up     = (p2_centre > ball_y_reg);
  assign p2_dn     = (p2_centre < ball_y_reg);
`else
  assign p2_up = i_P2_Up;
  assign p2_dn = i_P2_Dn;
`endif

  pong_paddle_ctrl #(
    .GAME_HEIGHT  (GAME_HEIGHT),
    .PADDLE_HEIGHT(PADDLE_HEIGHT),
    .PADDLE_SPEED (PADDLE_SPEED)
  ) u_paddle_p1 (
    .clk     (i_Clk),
    .srst    (i_Rst),
    .enable  (game_active_reg),
    .tick    (tick),
    .up      (i_P1_Up),
    .dn      (i_P1_Dn),
    .paddle_y(p1_y)
  );

  pong_paddle_ctrl #(
    .GAME_HEIGHT  (GAME_HEIGHT),
    .PADDLE_HEIGHT(PADDLE_HEIGHT),
    .PADDLE_SPEED (PADDLE_SPEED)
  ) u_paddle_p2 (
    .clk     (i_Clk),
    .srst    (i_Rst),
    .enable  (game_active_reg),
    .tick    (tick),
    .up      (p2_up),
    .dn      (p2_dn),
    .paddle_y(p2_y)
  );

  assign o_Ball_X      = ball_x_reg;
  assign o_Ball_Y      = ball_y_reg;
  assign o_P1_Paddle_Y = p1_y;
  assign o_P2_Paddle_Y = p2_y;
  assign o_P1_Score    = p1_score_reg;
  assign o_P2_Score    = p2_score_reg;
  assign o_Game_Active = game_active_reg;
  assign o_State       = state_reg;

endmodule

// File: doc/pong_game_ctrl.md
Name: pong_game_ctrl

Overview:
- Game-sequencing controller for the Pong datapath.
- Owns the game state machine, ball motion, both paddle positions and both scores, all in tile units on a 40x30 grid of 16x16-pixel tiles.
- Paced by frame ticks derived from the VGA VSync.
- Started by a UART RX data-valid pulse; its outputs feed the Pong pixel renderer.

Parameters:
GAME_WIDTH, 40, playfield width in tiles
GAME_HEIGHT, 30, playfield height in tiles
PADDLE_HEIGHT, 6, paddle length in tiles
PADDLE_COL_P1, 0, P1 paddle column
PADDLE_COL_P2, 39, P2 paddle column
BALL_SPEED, 8, frames per ball step (>=1)
PADDLE_SPEED, 4, frames per paddle step (>=1)
SERVE_FRAMES, 60, frames the ball is held before serving (>=1)
SCORE_LIMIT, 9, winning score (1..15)

Ports:
i_Clk  in  1  system clock (25 MHz)
i_Rst  in  1  reset
i_VSync  in  1  VGA vertical sync, active low
i_Start  in  1  one-cycle start pulse (UART o_RX_DV)
i_P1_Up, i_P1_Dn, i_P2_Up, i_P2_Dn  in  1 each  debounced switch levels
o_Ball_X  out  6  ball column
o_Ball_Y  out  5  ball row
o_P1_Paddle_Y, o_P2_Paddle_Y  out  5 each  paddle top row
o_P1_Score, o_P2_Score  out  4 each  scores
o_Game_Active  out  1  high in SERVE and RUNNING
o_State  out  3  current state encoding

Behaviour:
- Reset and clock: one clock, i_Clk. Reset i_Rst is synchronous and active-high.
- Reset values:
  - State IDLE.
  - Ball (20,15).
  - Paddles (GAME_HEIGHT-PADDLE_HEIGHT)/2 = 12.
  - Scores 0.
  - Ball direction +X,+Y.
  - o_Game_Active 0.
  - All frame counters 0.
  - Reset mid-game returns all of the above on the next edge.
- Frame tick:
  - i_VSync is registered.
  - Tick = previous 1 and current 0; it is a one-cycle pulse.
  - Everything below advances only on a tick, except i_Start handling.
- States:
  - IDLE(0): i_Start -> SERVE. Clear scores. Ball to centre. Serve direction +X.
  - SERVE(1):
    - Ball is held at (20,15).
    - The serve counter counts ticks.
    - At SERVE_FRAMES ticks -> RUNNING, and the ball counter is cleared.
  - RUNNING(2): the ball counter counts ticks. When it reaches BALL_SPEED-1 it wraps to 0 and the ball steps:
    - Y: moving down at GAME_HEIGHT-1, or up at 0 -> flip Y direction and step away from the wall in the same step. Otherwise step Y by +/-1.
    - X moving left with X == PADDLE_COL_P1+1:
      - If P1_Y <= Y <= P1_Y+PADDLE_HEIGHT-1 -> flip to +X and set X = PADDLE_COL_P1+2.
      - Otherwise -> POINT, scorer P2.
    - X moving right with X == PADDLE_COL_P2-1: mirror of the left case; a miss -> POINT, scorer P1.
    - Otherwise step X by +/-1.
    - X and Y updates are computed from the pre-step position in the same cycle.
  - POINT(3): lasts one cycle.
    - Increment the scorer's score, saturating at SCORE_LIMIT.
    - If the new score == SCORE_LIMIT -> GAME_OVER.
    - Otherwise -> SERVE, ball to centre, X direction toward the player who lost the point, Y direction +Y.
  - GAME_OVER(4):
    - Ball, paddles and scores are frozen.
    - i_Start -> SERVE with scores cleared and serve direction +X.
- Paddles move only in SERVE and RUNNING. Each has its own PADDLE_SPEED tick divider.
  - On a step: Up&&!Dn with Y>0 -> Y-1.
  - Dn&&!Up with Y<GAME_HEIGHT-PADDLE_HEIGHT -> Y+1.
  - Both pressed or neither pressed -> hold. Moves at either edge saturate.
- Priority and simultaneous events:
  - i_Start is ignored in SERVE, RUNNING and POINT.
  - A tick coinciding with i_Start in IDLE or GAME_OVER is consumed by the transition; counters start at 0.
  - A paddle step and a ball step on the same tick: the ball uses the pre-step paddle Y.
- Outputs are registered (no combinational path from inputs to outputs).

Optional Feature:
- Macro: PONG_AI_EN.
- Defined:
  - P2 paddle is driven internally; i_P2_Up and i_P2_Dn are ignored.
  - On each P2 paddle step, move one row toward aligning the paddle centre (Y+PADDLE_HEIGHT/2) with ball Y.
  - Hold when aligned. Same saturation rules as manual control.
- Undefined: P2 is controlled from the switches.

Decomposition:
- Shared package pong_pkg:
  - state enum (IDLE..GAME_OVER, 3-bit).
  - default grid and paddle constants.
  - coordinate widths (X 6 bits, Y 5 bits, score 4 bits).
- Sub-module pong_paddle_ctrl, instantiated twice:
  - contains the tick divider, up/down/hold logic and saturation.
  - has an enable input tied to o_Game_Active.

Test Plan (override BALL_SPEED=1, PADDLE_SPEED=1, SERVE_FRAMES=2 unless stated):
1. Assert i_Rst for 1 cycle during RUNNING -> next edge: IDLE, ball (20,15), both paddles 12, scores 0, o_Game_Active 0.
2. Pulse i_Start in IDLE, then 2 VSync falling edges -> state RUNNING, o_Game_Active 1. The next tick moves the ball to (21,16).
3. Hold i_P1_Up for 20 ticks in RUNNING -> o_P1_Paddle_Y decrements 12..0 over 12 ticks, then stays 0. Both buttons held -> no change.
4. P1 paddle at 24, ball reaches X=1 moving left at Y=10 -> POINT, o_P2_Score 1, SERVE with ball (20,15), serve direction -X.
5. Ball at Y=29 moving down -> next step Y=28 with direction up; X advances normally in the same step.
6. SCORE_LIMIT=2, two P2 misses -> o_P1_Score 2, GAME_OVER, o_Game_Active 0. Ticks change nothing. i_Start -> scores 0, state SERVE.
